// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire engine: state codes, frame length
// and the microsecond-to-cycle conversion.
package dht11_pkg;

  typedef logic [3:0] estado_t;

  localparam estado_t OCIOSO     = 4'd0;
  localparam estado_t INICIO     = 4'd1;
  localparam estado_t LIBERA     = 4'd2;
  localparam estado_t RESP_BAIXO = 4'd3;
  localparam estado_t RESP_ALTO  = 4'd4;
  localparam estado_t BIT_BAIXO  = 4'd5;
  localparam estado_t BIT_ALTO   = 4'd6;
  localparam estado_t VERIFICA   = 4'd7;
  localparam estado_t FIM        = 4'd8;

  localparam int FRAME_BITS = 40;

  function automatic int us_to_cycles(input int us, input int clk_hz);
    return us * (clk_hz / 1000000);
  endfunction

endpackage

// File: rtl/dht11_interface_if.sv
// Request/response bundle between the control unit (master) and the DHT11 engine (slave).
interface dht11_interface_if;
  // Handshake: medir is a one-cycle request, taken only while the engine is idle and
  // dropped otherwise; every taken request ends with exactly one pronto pulse, at which
  // point erro/umidade/temperatura are valid and stay valid until the next taken request.
  logic        medir;
  logic        pronto;
  logic        erro;
  logic [15:0] umidade;
  logic [15:0] temperatura;

  modport master (
    output medir,
    input  pronto,
    input  erro,
    input  umidade,
    input  temperatura
  );

  modport slave (
    input  medir,
    output pronto,
    output erro,
    output umidade,
    output temperatura
  );
endinterface

// File: rtl/dht11_sincronizador.sv
// Two-flop synchroniser for the raw data line plus rise/fall strobes of the synchronised level.
module dht11_sincronizador (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic subida,
  output logic descida
);

  logic meta;
  logic sinc;
  logic anterior;

  // The bus idles high through its pull-up, so reset to 1 to avoid a false fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta     <= 1'b1;
      sinc     <= 1'b1;
      anterior <= 1'b1;
    end else begin
      meta     <= entrada;
      sinc     <= meta;
      anterior <= sinc;
    end
  end

  assign subida  = sinc & ~anterior;
  assign descida = ~sinc & anterior;

endmodule

// File: rtl/dht11_interface.sv
// DHT11 protocol engine: start pulse, 40-bit frame decode, checksum check.
// Build option DHT11_CHECKSUM_EN: when defined, frames failing the checksum set erro.
module dht11_interface
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int START_US       = 18000,
  parameter int BIT1_LIMIAR_US = 48,
  parameter int TIMEOUT_US     = 200
) (
  input  logic                clock,
  input  logic                reset,
  dht11_interface_if.slave    bus,
  input  logic                dht11_in,
  output logic                dht11_oe,
  output logic [3:0]          db_estado
);

  localparam int START_CYC   = us_to_cycles(START_US, CLK_FREQ_HZ);
  localparam int BIT1_CYC    = us_to_cycles(BIT1_LIMIAR_US, CLK_FREQ_HZ);
  localparam int TIMEOUT_CYC = us_to_cycles(TIMEOUT_US, CLK_FREQ_HZ);
  localparam int TIMER_TOP   = (START_CYC > TIMEOUT_CYC) ? START_CYC : TIMEOUT_CYC;
  localparam int TW          = $clog2(TIMER_TOP + 1);

  estado_t       estado;
  estado_t       estado_next;
  logic [TW-1:0] timer;
  logic [5:0]    bit_cnt;
  logic [39:0]   quadro;
  logic          erro_q;
  logic [15:0]   umidade_q;
  logic [15:0]   temperatura_q;
  logic          subida;
  logic          descida;
  logic          timeout;
  logic          bit_val;
  logic          frame_ok;
  logic          pronto_c;

  dht11_sincronizador u_sinc (
    .clock   (clock),
    .reset   (reset),
    .entrada (dht11_in),
    .subida  (subida),
    .descida (descida)
  );

  assign timeout = (timer >= TW'(TIMEOUT_CYC));
  assign bit_val = (timer >= TW'(BIT1_CYC));

`ifdef DHT11_CHECKSUM_EN
  logic [7:0] soma;
  assign soma     = quadro[39:32] + quadro[31:24] + quadro[23:16] + quadro[15:8];
  assign frame_ok = (soma == quadro[7:0]);
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_next;
  end

  always_comb begin
    estado_next = estado;
    case (estado)
      OCIOSO:     if (bus.medir) estado_next = INICIO;
      INICIO:     if (timer == TW'(START_CYC - 1)) estado_next = LIBERA;
      LIBERA:     if (timeout) estado_next = FIM;
                  else if (descida) estado_next = RESP_BAIXO;
      RESP_BAIXO: if (timeout) estado_next = FIM;
                  else if (subida) estado_next = RESP_ALTO;
      RESP_ALTO:  if (timeout) estado_next = FIM;
                  else if (descida) estado_next = BIT_BAIXO;
      BIT_BAIXO:  if (timeout) estado_next = FIM;
                  else if (subida) estado_next = BIT_ALTO;
      BIT_ALTO:   if (timeout) estado_next = FIM;
                  else if (descida)
                    estado_next = (bit_cnt == 6'(FRAME_BITS - 1)) ? VERIFICA : BIT_BAIXO;
      VERIFICA:   estado_next = FIM;
      FIM:        estado_next = OCIOSO;
      default:    estado_next = OCIOSO;
    endcase
  end

  always_comb begin
    dht11_oe  = (estado == INICIO);
    pronto_c  = (estado == FIM);
    db_estado = estado;
  end

  // Timer restarts on every state change; held at zero while idle.
  always_ff @(posedge clock) begin
    if (reset || estado == OCIOSO || estado_next != estado) timer <= '0;
    else                                                    timer <= timer + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      erro_q        <= 1'b0;
      umidade_q     <= '0;
      temperatura_q <= '0;
      quadro        <= '0;
      bit_cnt       <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (bus.medir) begin
            erro_q  <= 1'b0;
            quadro  <= '0;
            bit_cnt <= '0;
          end
        end
        LIBERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO: begin
          if (timeout) erro_q <= 1'b1;
        end
        BIT_ALTO: begin
          if (timeout) begin
            erro_q <= 1'b1;
          end else if (descida) begin
            quadro  <= {quadro[38:0], bit_val};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        VERIFICA: begin
          if (frame_ok) begin
            umidade_q     <= quadro[39:24];
            temperatura_q <= quadro[23:8];
          end else begin
            erro_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pronto      = pronto_c;
  assign bus.erro        = erro_q;
  assign bus.umidade     = umidade_q;
  assign bus.temperatura = temperatura_q;

endmodule

// File: tb/tb_dht11_interface.sv
// Bench for dht11_interface: sensor waveform driver, frame-level reference model, scenario tasks.
module tb_dht11_interface;
  import dht11_pkg::*;

  localparam int START_US = 100;
  localparam int BIT1_US  = 48;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_drv = 1'b1;
  logic       line;
  logic       dht11_oe;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  dht11_interface_if bus_if ();

  assign line = dht11_oe ? 1'b0 : sensor_drv;

  dht11_interface #(
    .CLK_FREQ_HZ    (1000000),
    .START_US       (START_US),
    .BIT1_LIMIAR_US (BIT1_US),
    .TIMEOUT_US     (200)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_if),
    .dht11_in  (line),
    .dht11_oe  (dht11_oe),
    .db_estado (db_estado)
  );

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  int oe_run = 0;
  int last_oe_len = 0;

  logic [15:0] model_um = '0;
  logic [15:0] model_te = '0;
  logic [32:0] exp_q[$];
  int          hi_arr[40];
  logic [7:0]  frame_b[5];

  always @(negedge clock) begin
    if (bus_if.pronto) pronto_cnt <= pronto_cnt + 1;
    if (dht11_oe) begin
      oe_run <= oe_run + 1;
    end else begin
      if (oe_run != 0) last_oe_len <= oe_run;
      oe_run <= 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic lvl, input int us);
    sensor_drv = lvl;
    tick(us);
  endtask

  task automatic pulse_medir();
    bus_if.medir = 1'b1;
    tick(1);
    bus_if.medir = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int n;
    n = 0;
    while (dht11_oe && n < 300) begin
      tick(1);
      n++;
    end
    ok = (n > 0) && (n < 300);
  endtask

  task automatic fill_hi();
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 8; j++)
        hi_arr[k*8 + j] = frame_b[k][7-j] ? int'($urandom_range(65, 75))
                                          : int'($urandom_range(20, 30));
  endtask

  // Reference decode: a bit is 1 when its high pulse lasts at least BIT1_US microseconds.
  function automatic logic [39:0] decode_frame();
    logic [39:0] f;
    f = '0;
    for (int i = 0; i < 40; i++) f = {f[38:0], (hi_arr[i] >= BIT1_US)};
    return f;
  endfunction

  task automatic send_preamble();
    drive(1'b1, 30);
    drive(1'b0, 80);
    drive(1'b1, 80);
  endtask

  task automatic run_frame(input string name);
    bit          ok;
    bit          good;
    int          p0;
    logic [39:0] f;
    logic [7:0]  sum;
    logic [32:0] e;
    f   = decode_frame();
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
`ifdef DHT11_CHECKSUM_EN
    good = (sum == f[7:0]);
`else
    good = 1'b1;
`endif
    if (good) begin
      model_um = f[39:24];
      model_te = f[23:8];
    end
    exp_q.push_back({~good, model_um, model_te});
    p0 = pronto_cnt;
    pulse_medir();
    wait_release(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s release: oe=%0b, required a finite start pulse", name, dht11_oe); end
    send_preamble();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 50);
      drive(1'b1, hi_arr[i]);
    end
    drive(1'b0, 50);
    sensor_drv = 1'b1;
    tick(20);
    e = exp_q.pop_front();
    checks++;
    if (last_oe_len !== START_US) begin errors++; $display("FAIL %s oe_len: got %0d, required %0d", name, last_oe_len, START_US); end
    checks++;
    if (pronto_cnt - p0 !== 1) begin errors++; $display("FAIL %s pronto_count: got %0d, required 1", name, pronto_cnt - p0); end
    checks++;
    if (bus_if.erro !== e[32]) begin errors++; $display("FAIL %s erro: got %0b, required %0b", name, bus_if.erro, e[32]); end
    checks++;
    if (bus_if.umidade !== e[31:16]) begin errors++; $display("FAIL %s umidade: got %h, required %h", name, bus_if.umidade, e[31:16]); end
    checks++;
    if (bus_if.temperatura !== e[15:0]) begin errors++; $display("FAIL %s temperatura: got %h, required %h", name, bus_if.temperatura, e[15:0]); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.medir = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++;
    if (dht11_oe !== 1'b0) begin errors++; $display("FAIL reset oe: got %0b, required 0", dht11_oe); end
    checks++;
    if (bus_if.pronto !== 1'b0) begin errors++; $display("FAIL reset pronto: got %0b, required 0", bus_if.pronto); end
    checks++;
    if (bus_if.erro !== 1'b0) begin errors++; $display("FAIL reset erro: got %0b, required 0", bus_if.erro); end
    checks++;
    if (bus_if.umidade !== 16'h0) begin errors++; $display("FAIL reset umidade: got %h, required 0000", bus_if.umidade); end
    checks++;
    if (bus_if.temperatura !== 16'h0) begin errors++; $display("FAIL reset temperatura: got %h, required 0000", bus_if.temperatura); end
    checks++;
    if (db_estado !== OCIOSO) begin errors++; $display("FAIL reset state: got %0d, required %0d", db_estado, OCIOSO); end
  endtask

  task automatic test_good_frame(input string name);
    frame_b[0] = 8'h37; frame_b[1] = 8'h00; frame_b[2] = 8'h19; frame_b[3] = 8'h00; frame_b[4] = 8'h50;
    fill_hi();
    run_frame(name);
  endtask

  task automatic test_bad_checksum();
    frame_b[0] = 8'h37; frame_b[1] = 8'h00; frame_b[2] = 8'h19; frame_b[3] = 8'h00; frame_b[4] = 8'h51;
    fill_hi();
    run_frame("bad_checksum");
  endtask

  task automatic test_bit_threshold();
    logic [7:0] s;
    frame_b[2] = 8'h21; frame_b[3] = 8'h05;
    fill_hi();
    for (int i = 0; i < 16; i++) hi_arr[i] = (i % 2 == 0) ? 49 : 47;
    s = 8'hAA + 8'hAA + frame_b[2] + frame_b[3];
    for (int j = 0; j < 8; j++) hi_arr[32 + j] = s[7-j] ? 70 : 25;
    run_frame("bit_threshold");
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 4; k++) frame_b[k] = 8'($urandom_range(0, 255));
      frame_b[4] = frame_b[0] + frame_b[1] + frame_b[2] + frame_b[3];
      if ($urandom_range(0, 1) == 1) frame_b[4] = frame_b[4] + 8'($urandom_range(1, 255));
      fill_hi();
      run_frame("random_frame");
    end
  endtask

  task automatic test_no_sensor();
    bit ok;
    int n;
    sensor_drv = 1'b1;
    pulse_medir();
    wait_release(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL no_sensor release: oe=%0b, required a finite start pulse", dht11_oe); end
    n = 0;
    while (!bus_if.pronto && n < 300) begin tick(1); n++; end
    checks++;
    if (n < 200 || n > 202) begin errors++; $display("FAIL no_sensor timeout_latency: got %0d cycles, required 200..202", n); end
    checks++;
    if (bus_if.erro !== 1'b1) begin errors++; $display("FAIL no_sensor erro: got %0b, required 1", bus_if.erro); end
    tick(1);
    checks++;
    if (bus_if.pronto !== 1'b0) begin errors++; $display("FAIL no_sensor pronto_width: got %0b, required 0", bus_if.pronto); end
    checks++;
    if (bus_if.umidade !== model_um) begin errors++; $display("FAIL no_sensor umidade: got %h, required %h", bus_if.umidade, model_um); end
    pulse_medir();
    checks++;
    if (bus_if.erro !== 1'b0) begin errors++; $display("FAIL no_sensor erro_clear: got %0b, required 0", bus_if.erro); end
    tick(420);
  endtask

  task automatic test_interference();
    bit ok;
    int p0;
    p0 = pronto_cnt;
    pulse_medir();
    tick(10);
    pulse_medir();
    wait_release(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL interference release: oe=%0b, required a finite start pulse", dht11_oe); end
    tick(300);
    checks++;
    if (pronto_cnt - p0 !== 1) begin errors++; $display("FAIL interference pronto_count: got %0d, required 1", pronto_cnt - p0); end
    checks++;
    if (last_oe_len !== START_US) begin errors++; $display("FAIL interference oe_len: got %0d, required %0d", last_oe_len, START_US); end
    checks++;
    if (bus_if.erro !== 1'b1) begin errors++; $display("FAIL interference erro: got %0b, required 1", bus_if.erro); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    frame_b[0] = 8'hC3; frame_b[1] = 8'h00; frame_b[2] = 8'h00; frame_b[3] = 8'h00; frame_b[4] = 8'hC3;
    fill_hi();
    pulse_medir();
    wait_release(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid release: oe=%0b, required a finite start pulse", dht11_oe); end
    send_preamble();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 50);
      drive(1'b1, hi_arr[i]);
    end
    drive(1'b0, 50);
    sensor_drv = 1'b1;
    tick(10);
    checks++;
    if (db_estado !== BIT_ALTO) begin errors++; $display("FAIL reset_mid pre_state: got %0d, required %0d", db_estado, BIT_ALTO); end
    reset = 1'b1;
    tick(1);
    checks++;
    if (db_estado !== OCIOSO) begin errors++; $display("FAIL reset_mid state: got %0d, required %0d", db_estado, OCIOSO); end
    checks++;
    if (dht11_oe !== 1'b0) begin errors++; $display("FAIL reset_mid oe: got %0b, required 0", dht11_oe); end
    checks++;
    if (bus_if.umidade !== 16'h0) begin errors++; $display("FAIL reset_mid umidade: got %h, required 0000", bus_if.umidade); end
    reset = 1'b0;
    model_um = '0;
    model_te = '0;
    tick(100);
  endtask

  initial begin
    bus_if.medir = 1'b0;
    test_reset();
    test_good_frame("good_frame");
    test_bad_checksum();
    test_bit_threshold();
    test_random_frames();
    test_no_sensor();
    test_interference();
    test_reset_mid();
    test_good_frame("recovery_frame");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
